// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: stores {instr, pc, pcplus4} in a
// circular array, presents the head first-word-fall-through, and empties on flush.
module fetch_buffer #(
  parameter int               DEPTH = 4,
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_instr,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [WIDTH-1:0]       in_pcplus4,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_instr,
  output logic [WIDTH-1:0]       out_pc,
  output logic [WIDTH-1:0]       out_pcplus4,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] instr_mem   [DEPTH];
  logic [WIDTH-1:0] pc_mem      [DEPTH];
  logic [WIDTH-1:0] pcplus4_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;

  // Handshake: a transfer happens on a side in any cycle where its valid and
  // ready are both high. Ready on both sides is a function of occupancy only,
  // and a flush cancels both transfers in its cycle.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  assign out_instr   = out_valid ? instr_mem[rd_ptr]   : NOP;
  assign out_pc      = out_valid ? pc_mem[rd_ptr]      : '0;
  assign out_pcplus4 = out_valid ? pcplus4_mem[rd_ptr] : '0;

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr]   <= in_instr;
      pc_mem[wr_ptr]      <= in_pc;
      pcplus4_mem[wr_ptr] <= in_pcplus4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam int          W     = 32;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_instr;
  logic [W-1:0] in_pc;
  logic [W-1:0] in_pcplus4;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_instr;
  logic [W-1:0] out_pc;
  logic [W-1:0] out_pcplus4;
  logic [2:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue entry per stored word, {instr, pc, pcplus4}.
  logic [3*W-1:0] exp_q[$];

  fetch_buffer #(.DEPTH(DEPTH), .WIDTH(W), .NOP(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_pcplus4 (in_pcplus4),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_pcplus4(out_pcplus4),
    .count      (count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Driver: present a word and handshake controls for the next edge.
  task automatic drive(input logic f, input logic iv, input logic [31:0] instr,
                       input logic [31:0] pc, input logic ordy);
    flush      = f;
    in_valid   = iv;
    in_instr   = instr;
    in_pc      = pc;
    in_pcplus4 = pc + 32'd4;
    out_ready  = ordy;
  endtask

  // Advance one clock, applying the same rules to the model queue.
  task automatic step();
    bit do_push, do_pop;
    logic [3*W-1:0] word;
    do_push = !flush && in_valid && (exp_q.size() < DEPTH);
    do_pop  = !flush && out_ready && (exp_q.size() > 0);
    word    = {in_instr, in_pc, in_pcplus4};
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(word);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3*W-1:0] head;
    bit v;
    v    = exp_q.size() > 0;
    head = v ? exp_q[0] : {NOP, 32'd0, 32'd0};
    chk({tag, ".count"},     32'(count),     32'(exp_q.size()));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_instr"}, out_instr,      head[3*W-1:2*W]);
    chk({tag, ".out_pc"},    out_pc,         head[2*W-1:W]);
    chk({tag, ".out_pcp4"},  out_pcplus4,    head[W-1:0]);
  endtask

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] exp_count;
    logic        exp_valid;
    logic        exp_in_ready;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // flush, in_valid, out_ready, in_instr, in_pc, count, valid, in_ready, head instr, head pc
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h00500093, 32'h00, 32'd1, 1'b1, 1'b1, 32'h00500093, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h00a00113, 32'h04, 32'd2, 1'b1, 1'b1, 32'h00500093, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h002081b3, 32'h08, 32'd3, 1'b1, 1'b1, 32'h00500093, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h00312023, 32'h0c, 32'd4, 1'b1, 1'b0, 32'h00500093, 32'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h00012203, 32'h10, 32'd4, 1'b1, 1'b0, 32'h00500093, 32'h00};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h00012203, 32'h10, 32'd4, 1'b1, 1'b0, 32'h00500093, 32'h00};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h00012203, 32'h10, 32'd3, 1'b1, 1'b1, 32'h00a00113, 32'h04};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h00012203, 32'h10, 32'd4, 1'b1, 1'b0, 32'h00a00113, 32'h04};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00, 32'd3, 1'b1, 1'b1, 32'h002081b3, 32'h08};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00, 32'd2, 1'b1, 1'b1, 32'h00312023, 32'h0c};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00, 32'd1, 1'b1, 1'b1, 32'h00012203, 32'h10};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h0000006f, 32'h14, 32'd0, 1'b0, 1'b1, NOP,          32'h00};
  end

  initial begin
    // Reset with fetch already offering a word
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h00500093, 32'h0, 1'b0);
    #2;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_instr", out_instr, NOP);
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_clk.count", 32'(count), 32'd0);
    chk("reset_clk.out_pc", out_pc, 32'd0);
    chk("reset_clk.out_pcp4", out_pcplus4, 32'd0);
    exp_q.delete();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vector table: fill, hold while full, pop+push at full, drain, flush
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_instr, vecs[i].in_pc, vecs[i].out_ready);
      step();
      chk({tag, ".count"},     32'(count),     vecs[i].exp_count);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(vecs[i].exp_valid));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(vecs[i].exp_in_ready));
      chk({tag, ".out_instr"}, out_instr,      vecs[i].exp_instr);
      chk({tag, ".out_pc"},    out_pc,         vecs[i].exp_pc);
      chk({tag, ".out_pcp4"},  out_pcplus4,    vecs[i].exp_valid ? vecs[i].exp_pc + 32'd4 : 32'd0);
    end

    // Steady stream at count=2: pointers wrap several times
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'h1000 + 32'(i), 32'h100 + 32'(4 * i), 1'b0);
      step();
    end
    for (int i = 2; i < 12; i++) begin
      drive(1'b0, 1'b1, 32'h1000 + 32'(i), 32'h100 + 32'(4 * i), 1'b1);
      step();
      chk($sformatf("stream%0d.count", i), 32'(count), 32'd2);
      check_model($sformatf("stream%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      step();
      check_model($sformatf("drain%0d", i));
    end

    // Flush at count=3 with a push and a pop offered in the same cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h2000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0);
      step();
    end
    chk("preflush.count", 32'(count), 32'd3);
    drive(1'b1, 1'b1, 32'hdeadbeef, 32'h20c, 1'b1);
    step();
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.out_instr", out_instr, NOP);
    drive(1'b0, 1'b1, 32'h00000537, 32'h400, 1'b0);
    step();
    chk("redirect.count", 32'(count), 32'd1);
    chk("redirect.out_instr", out_instr, 32'h00000537);
    chk("redirect.out_pc", out_pc, 32'h400);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("redirect_pop.out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset between clock edges
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'h3000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0);
      step();
    end
    #2 rst = 1'b0;
    #1;
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_model("post_rst");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, $urandom(),
            $urandom() & 32'hfffffffc, $urandom_range(0, 9) < 6);
      step();
      check_model($sformatf("rand%0d", i));
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
